counter_mod: RTL and testbench

COUNTER_MOD -- requirements
Module: counter_mod

---
 rtl/counter_pkg.sv | 20 ++
 rtl/counter_mod_oreg.sv | 28 ++
 rtl/counter_mod.sv | 83 ++++++++
 tb/tb_counter_mod.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for counter_mod: direction encoding and the load clamp helper.
// Saturating boundary behaviour is selected with the COUNTER_MOD_SATURATE_EN macro.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Widest legal counter; callers zero-extend into this and truncate back.
  localparam int unsigned CNT_MAX_WIDTH = 32;

  function automatic logic [CNT_MAX_WIDTH-1:0] clamp_max(
    input logic [CNT_MAX_WIDTH-1:0] val,
    input logic [CNT_MAX_WIDTH-1:0] max_val
  );
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/counter_mod_oreg.sv
// Output register stage: delays {tc flag, count} by one clock to form q and tc.
// Synchronous active-low reset to q=INIT, tc=0.
module counter_mod_oreg
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH = 5,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH:0]   d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  logic [WIDTH:0] stage;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage <= {1'b0, INIT};
    end else begin
      stage <= d;
    end
  end

  assign {tc, q} = stage;

endmodule

// File: rtl/counter_mod.sv
// Up/down counter with clamped synchronous load, wrap-or-saturate boundary and
// registered q/tc. Define COUNTER_MOD_SATURATE_EN to hold at the bounds instead of wrapping.
module counter_mod
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 5,
  parameter logic [WIDTH-1:0] MAX_VAL = '1,
  parameter logic [WIDTH-1:0] INIT    = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             flag;
  logic             flag_nxt;
  logic [WIDTH-1:0] load_clamped;

  assign load_clamped = WIDTH'(clamp_max(CNT_MAX_WIDTH'(load_val), CNT_MAX_WIDTH'(MAX_VAL)));

  // flag marks a boundary event on this edge; it is never held, so each
  // event yields exactly one tc cycle unless the bound is pushed again.
  always_comb begin
    cnt_nxt  = cnt;
    flag_nxt = 1'b0;
    if (load) begin
      cnt_nxt = load_clamped;
    end else if (en) begin
      if (dir_e'(up) == DIR_UP) begin
        if (cnt >= MAX_VAL) begin
          flag_nxt = 1'b1;
`ifdef COUNTER_MOD_SATURATE_EN
          cnt_nxt  = MAX_VAL;
`else
          cnt_nxt  = '0;
`endif
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end else begin
        if (cnt == '0) begin
          flag_nxt = 1'b1;
`ifdef COUNTER_MOD_SATURATE_EN
          cnt_nxt  = '0;
`else
          cnt_nxt  = MAX_VAL;
`endif
        end else begin
          cnt_nxt = cnt - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= INIT;
      flag <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      flag <= flag_nxt;
    end
  end

  counter_mod_oreg #(
    .WIDTH (WIDTH),
    .INIT  (INIT)
  ) u_oreg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({flag, cnt}),
    .q     (q),
    .tc    (tc)
  );

endmodule

// File: tb/tb_counter_mod.sv
// Directed self-checking bench for counter_mod (WIDTH=5, MAX_VAL=20, INIT=0).
// Expectations follow the wrap build unless COUNTER_MOD_SATURATE_EN is defined.
module tb_counter_mod;

  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  counter_mod #(
    .WIDTH   (W),
    .MAX_VAL (5'd20),
    .INIT    (5'd0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ld, input logic [W-1:0] lv,
                       input logic e, input logic u);
    rst_n    = r;
    load     = ld;
    load_val = lv;
    en       = e;
    up       = u;
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int unsigned eq, input bit etc);
    check({tag, "_q"}, 32'(q), eq);
    check({tag, "_tc"}, 32'(tc), 32'(etc));
  endtask

  initial begin
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    tick();
    expect_out("reset", 0, 1'b0);

    // Count up through the terminal value; 22nd edge shows the post-wrap value.
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    for (int k = 1; k <= 22; k++) begin
      tick();
`ifdef COUNTER_MOD_SATURATE_EN
      expect_out($sformatf("up%0d", k), (k <= 21) ? k - 1 : 20, k == 22);
`else
      expect_out($sformatf("up%0d", k), (k <= 21) ? k - 1 : 0, k == 22);
`endif
    end

    // Load above MAX_VAL is clamped to 20.
    drive(1'b1, 1'b1, 5'd31, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    expect_out("load_clamp", 20, 1'b0);

    // Load at the terminal count wins over the wrap.
    drive(1'b1, 1'b1, 5'd7, 1'b1, 1'b1);
    tick();
    expect_out("load_bound_a", 20, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    expect_out("load_bound_b", 7, 1'b0);

    // Decrement below zero.
    drive(1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    expect_out("down_g", 0, 1'b0);
    tick();
`ifdef COUNTER_MOD_SATURATE_EN
    expect_out("down_h", 0, 1'b1);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    expect_out("down_i", 0, 1'b1);
`else
    expect_out("down_h", 20, 1'b1);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    expect_out("down_i", 19, 1'b0);
`endif

    // Direction change takes effect on the very edge it is applied.
    drive(1'b1, 1'b1, 5'd10, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    expect_out("tog1", 10, 1'b0);
    up = 1'b0;
    tick();
    expect_out("tog2", 11, 1'b0);
    up = 1'b1;
    tick();
    expect_out("tog3", 10, 1'b0);
    en = 1'b0;
    tick();
    expect_out("tog4", 11, 1'b0);

    // Plain decrement 3 -> 0, then hold.
    drive(1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("dn%0d", k), 3 - k, 1'b0);
    end
    en = 1'b0;
    tick();
    expect_out("dn_hold", 0, 1'b0);

    // Reset mid-count with load asserted.
    drive(1'b1, 1'b1, 5'd11, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b1, 5'd9, 1'b1, 1'b1);
    tick();
    expect_out("rst_mid", 0, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("rst_hold%0d", k), 0, 1'b0);
    end

    // Reset on the edge after a wrap discards the pending tc.
    drive(1'b1, 1'b1, 5'd20, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    expect_out("pre_wrap", 20, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    expect_out("rst_after_wrap", 0, 1'b0);

    // Reset on the boundary edge itself.
    drive(1'b1, 1'b1, 5'd20, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    expect_out("rst_on_bound", 0, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    expect_out("post_rst1", 0, 1'b0);
    tick();
    expect_out("post_rst2", 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
